// File: rtl/melbank_rd_ctrl.sv
`timescale 1ns/1ps
// melbank_rd_ctrl: burst reader for the mel filterbank coefficient ROM.
// Issues addresses under credit control and streams the returned words through a small FIFO.
module melbank_rd_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8,
   parameter int ROM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int FIFO_D = ROM_LAT + 2;
   localparam int CW     = $clog2(FIFO_D + 1);
   localparam int SW     = $clog2(2 * FIFO_D + 2);
   localparam int LW     = ADDR_WIDTH + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_rom_addr;
   logic [LW-1:0]         r_len;
   logic [LW-1:0]         r_iss_cnt;
   logic [LW-1:0]         r_dlv_cnt;
   logic [ROM_LAT:0]      r_pv;
   logic [DATA_WIDTH-1:0] r_q [FIFO_D];
   logic [CW-1:0]         r_cnt;
   logic                  r_m_valid;
   logic                  r_done;

   logic          w_busy;
   logic          w_abort;
   logic          w_start;
   logic          w_accept;
   logic          w_pop;
   logic          w_last;
   logic          w_cap;
   logic          w_issue;
   logic [SW-1:0] w_inflight;
   logic [SW-1:0] w_total;
   logic [CW-1:0] w_wr_idx;
   logic [CW-1:0] w_cnt_nxt;

   assign w_busy   = (r_state != S_IDLE);
   assign w_abort  = abort & w_busy;
   // abort outranks a simultaneous start, so a cancelled request is never accepted
   assign w_start  = start & ~w_busy & ~abort;
   assign w_accept = w_start & (len != '0);
   assign w_pop    = r_m_valid & m_ready;
   assign w_last   = r_m_valid & (r_dlv_cnt == r_len - LW'(1));
   assign w_cap    = r_pv[ROM_LAT];

   // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
         w_inflight = w_inflight + SW'(r_pv[i]);
      end
   end

   // Credit check: reads in flight plus FIFO words, net of this cycle's pop, must leave room.
   assign w_total   = w_inflight + SW'(r_cnt) - SW'(w_pop);
   assign w_issue   = (r_state == S_FETCH) & (r_iss_cnt != r_len) & (w_total < SW'(FIFO_D)) & ~abort;
   assign w_wr_idx  = r_cnt - CW'(w_pop);
   assign w_cnt_nxt = r_cnt + CW'(w_cap) - CW'(w_pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rom_addr <= '0;
         r_len      <= '0;
         r_iss_cnt  <= '0;
         r_dlv_cnt  <= '0;
         r_pv       <= '0;
         r_cnt      <= '0;
         r_m_valid  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_state   <= S_IDLE;
            r_pv      <= '0;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
         end else begin
            r_pv      <= {r_pv[ROM_LAT-1:0], w_issue | w_accept};
            r_cnt     <= w_cnt_nxt;
            r_m_valid <= (w_cnt_nxt != '0);
            if (w_pop) begin
               r_dlv_cnt <= r_dlv_cnt + LW'(1);
            end
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_state    <= S_FETCH;
                     r_len      <= len;
                     r_iss_cnt  <= LW'(1);
                     r_dlv_cnt  <= '0;
                     r_rom_addr <= base_addr;
                  end else if (w_start) begin
                     r_done <= 1'b1;
                  end
               end
               S_FETCH: begin
                  if (r_iss_cnt == r_len) begin
                     r_state <= S_DRAIN;
                  end else if (w_issue) begin
                     r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
                     r_iss_cnt  <= r_iss_cnt + LW'(1);
                  end
               end
               S_DRAIN: begin
                  if (w_pop && w_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // NOTE: this FIFO is a handful of flops whose head is the m_data register, so it is reset to give m_data=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_D; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FIFO_D - 1; i++) begin
            if (w_pop) begin
               r_q[i] <= r_q[i+1];
            end
         end
         for (int i = 0; i < FIFO_D; i++) begin
            if (w_cap && !w_abort && (w_wr_idx == CW'(i))) begin
               r_q[i] <= rom_data;
            end
         end
      end
   end

   assign rom_addr = r_rom_addr;
   assign m_data   = r_q[0];
   assign m_valid  = r_m_valid;
   assign m_last   = w_last;
   assign busy     = w_busy;
   assign done     = r_done;

endmodule
